iic_slave_rx: RTL

I2C target-side write receiver: the far end of the `iic_opr` master write path. It oversamples `scl`/`sda` on the system clock and detects START/STOP. It matches a 7-bit address and ACKs or NACKs each byte. Received data bytes leave on an AXI4-Stream master port, with `tlast` marking the final byte of each transaction. It sits between the board I2C pins (open-drain buffers outside) and any byte consumer, e.g. a register file or display driver front end.

---
 rtl/iic_pkg.sv | 17 +
 rtl/iic_line_filter.sv | 55 +++++
 rtl/iic_slave_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/iic_pkg.sv
// Shared I2C definitions used by both the master (iic_opr) and target (iic_slave_rx) sides:
// FSM state encoding, ACK/NACK line levels and the address width.
package iic_pkg;
    localparam int   IIC_ADDR_W = 7;
    localparam logic IIC_ACK    = 1'b0;
    localparam logic IIC_NACK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE,
        ST_STRETCH
    } iic_state_e;
endpackage

// File: rtl/iic_line_filter.sv
// Pad conditioning for one I2C line: 2-flop synchronizer, FILTER_LEN-sample glitch
// filter, and single-cycle rise/fall pulses aligned with the filtered level change.
module iic_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync_q, sync_d;
    logic       filt_q, filt_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[0], line_in};
        filt_d = filt_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // the FILTER_LEN-th consecutive differing sample flips the level
        if (sync_q[1] != filt_q) begin
            if (cnt_q == 3'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
                rise_d = sync_q[1];
                fall_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = filt_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/iic_slave_rx.sv
// I2C target write receiver: address match, per-byte ACK/NACK, bytes out on AXI4-Stream.
// Optional clock stretching on a full buffer is compiled in with IIC_SLAVE_RX_STRETCH_EN.
module iic_slave_rx
    import iic_pkg::*;
#(
    parameter logic [IIC_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int                    FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       busy,
    output logic       overrun
);
    logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .resetn(resetn), .line_in(scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .resetn(resetn), .line_in(sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    iic_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sr_q, sr_d, pend_q, pend_d, tdata_q, tdata_d;
    logic       sda_oe_q, sda_oe_d, busy_q, busy_d, overrun_q, overrun_d;
    logic       pend_vld_q, pend_vld_d, flush_q, flush_d;
    logic       tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic       start_ev, stop_ev, hs, slot_free, room, store, resp, flush_now, move;
`ifdef IIC_SLAVE_RX_STRETCH_EN
    logic       scl_oe_q, scl_oe_d;
`endif

    assign start_ev  = sda_fall && scl_lvl;
    assign stop_ev   = sda_rise && scl_lvl;
    assign hs        = tvalid_q && m_axis_tready;
    assign slot_free = !tvalid_q || hs;
    assign room      = !pend_vld_q || slot_free;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        overrun_d = 1'b0;
        store     = 1'b0;
        resp      = IIC_NACK;
`ifdef IIC_SLAVE_RX_STRETCH_EN
        scl_oe_d  = scl_oe_q;
`endif
        case (state_q)
            ST_ADDR: if (scl_rise) begin
                sr_d      = {sr_q[6:0], sda_lvl};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    resp    = (sr_d[7:1] == SLAVE_ADDR && !sr_d[0]) ? IIC_ACK : IIC_NACK;
                    state_d = (resp == IIC_ACK) ? ST_ADDR_ACK : ST_IGNORE;
                    busy_d  = (resp == IIC_ACK);
                end
            end
            // first fall after bit 8 starts the ACK, the second one ends it
            ST_ADDR_ACK: if (scl_fall) begin
                sda_oe_d = !sda_oe_q;
                if (sda_oe_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (scl_rise && bit_cnt_q != 4'd8) begin
                    sr_d      = {sr_q[6:0], sda_lvl};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    resp     = room ? IIC_ACK : IIC_NACK;
                    store    = (resp == IIC_ACK);
                    sda_oe_d = (resp == IIC_ACK);
                    if (resp == IIC_ACK) begin
                        state_d = ST_DATA_ACK;
                    end else begin
`ifdef IIC_SLAVE_RX_STRETCH_EN
                        state_d  = ST_STRETCH;
                        scl_oe_d = 1'b1;
`else
                        state_d   = ST_IGNORE;
                        overrun_d = 1'b1;
`endif
                    end
                end
            end
`ifdef IIC_SLAVE_RX_STRETCH_EN
            ST_STRETCH: if (room) begin
                store    = 1'b1;
                sda_oe_d = 1'b1;
                scl_oe_d = 1'b0;
                state_d  = ST_DATA_ACK;
            end
`endif
            ST_DATA_ACK: if (scl_fall) begin
                sda_oe_d  = 1'b0;
                state_d   = ST_DATA;
                bit_cnt_d = '0;
            end
            ST_IDLE, ST_IGNORE: ;
            default: state_d = ST_IDLE;
        endcase

        if (stop_ev || start_ev) begin
            state_d   = stop_ev ? ST_IDLE : ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            store     = 1'b0;
`ifdef IIC_SLAVE_RX_STRETCH_EN
            scl_oe_d  = 1'b0;
`endif
        end
    end

    // A STOP/START flush waits in flush_q while the AXIS slot is blocked.
    always_comb begin
        flush_now  = flush_q || ((start_ev || stop_ev) && pend_vld_q);
        move       = pend_vld_q && slot_free && (store || flush_now);
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        flush_d    = flush_now;
        tvalid_d   = tvalid_q && !hs;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        if (move) begin
            tvalid_d   = 1'b1;
            tdata_d    = pend_q;
            tlast_d    = flush_now;
            pend_vld_d = 1'b0;
            flush_d    = 1'b0;
        end
        if (store) begin
            pend_d     = sr_q;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            flush_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            flush_q    <= flush_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
        end
    end

`ifdef IIC_SLAVE_RX_STRETCH_EN
    always_ff @(posedge clk) begin
        if (!resetn) scl_oe_q <= 1'b0;
        else         scl_oe_q <= scl_oe_d;
    end
    assign scl_oe = scl_oe_q;
`else
    assign scl_oe = 1'b0;
`endif

    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
endmodule
